// File: rtl/io_display_port.sv
// ============================================================================
// Module      : io_display_port
// Description : Memory-mapped display/LED output port on the CPU data bus.
//               Decodes writes in the upper address half (address[15]=1).
//               Holds a 16-bit display value, 3 control bits and a 10-bit LED
//               word. Drives four active-low 7-segment digits with
//               leading-zero blanking and a prescaled blink.
//               Provides a combinational read-back path for the top level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_display_port #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] address,
    input  logic [31:0] data,
    input  logic        wren,
    output logic        io_sel,
    output logic [31:0] io_q,
    output logic [9:0]  LEDG,
    output logic [6:0]  HEX0_D,
    output logic [6:0]  HEX1_D,
    output logic [6:0]  HEX2_D,
    output logic [6:0]  HEX3_D
);

    // Register addresses, decoded on the full 16-bit bus address
    localparam logic [15:0] c_ADDR_DISP = 16'h8000;
    localparam logic [15:0] c_ADDR_CTRL = 16'h8001;
    localparam logic [15:0] c_ADDR_LED  = 16'h8002;

    // Control register reset value: display enabled, no blanking, no blink
    localparam logic [2:0]  c_CTRL_RST  = 3'b001;

    // Segment pattern with every segment off (active-low)
    localparam logic [6:0]  c_SEG_OFF   = 7'h7F;

    // Blink prescaler counter sizing
    localparam int c_CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BLINK_DIV - 1);

    // Architectural state
    logic [15:0]        r_disp;
    logic [2:0]         r_ctrl;
    logic [9:0]         r_led;
    logic [c_CNT_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic [6:0]         r_hex [4];

    // Decoded write strobes
    logic w_wr_disp;
    logic w_wr_ctrl;
    logic w_wr_led;

    // Per-digit display pipeline signals
    logic [6:0] w_seg      [4];
    logic [6:0] w_hex_next [4];
    logic [3:0] w_zero;
    logic [3:0] w_blank;
    logic       w_all_off;

    // Hex digit to active-low {g,f,e,d,c,b,a} segment pattern
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Full-address write decode; the address comparison implies address[15]=1
    always_comb begin
        w_wr_disp = wren && (address == c_ADDR_DISP);
        w_wr_ctrl = wren && (address == c_ADDR_CTRL);
        w_wr_led  = wren && (address == c_ADDR_LED);
    end

    // Register file writes; unused data bits are simply not stored
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_disp <= '0;
            r_ctrl <= c_CTRL_RST;
            r_led  <= '0;
        end else begin
            if (w_wr_disp) r_disp <= data[15:0];
            if (w_wr_ctrl) r_ctrl <= data[2:0];
            if (w_wr_led)  r_led  <= data[9:0];
        end
    end

    // Free-running blink prescaler; a CTRL write restarts it and beats a wrap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == c_CNT_MAX) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + c_CNT_W'(1);
        end
    end

    // Whole-display blanking: disabled, or blink active in its off phase
    always_comb begin
        w_all_off = !r_ctrl[0] || (r_ctrl[2] && r_blink_phase);
    end

    // Leading-zero blanking: a digit blanks only if it and all higher digits are zero
    always_comb begin
        w_blank    = 4'b0000;
        w_blank[3] = r_ctrl[1] && w_zero[3];
        w_blank[2] = w_blank[3] && w_zero[2];
        w_blank[1] = w_blank[2] && w_zero[1];
    end

    // Per-digit decode and final output selection
    for (genvar k = 0; k < 4; k++) begin : g_digit
        assign w_zero[k]     = (r_disp[4*k +: 4] == 4'h0);
        assign w_seg[k]      = seg7(r_disp[4*k +: 4]);
        assign w_hex_next[k] = (w_all_off || w_blank[k]) ? c_SEG_OFF : w_seg[k];
    end

    // Segment outputs are registered one edge behind the register state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_hex[i] <= c_SEG_OFF;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_hex[i] <= w_hex_next[i];
            end
        end
    end

    // Combinational read-back for the CPU read data mux
    always_comb begin
        case (address)
            c_ADDR_DISP: io_q = {16'h0000, r_disp};
            c_ADDR_CTRL: io_q = {29'h0, r_ctrl};
            c_ADDR_LED:  io_q = {22'h0, r_led};
            default:     io_q = 32'h0000_0000;
        endcase
    end

    assign io_sel = address[15];
    assign LEDG   = r_led;
    assign HEX0_D = r_hex[0];
    assign HEX1_D = r_hex[1];
    assign HEX2_D = r_hex[2];
    assign HEX3_D = r_hex[3];

endmodule

`default_nettype wire

// File: doc/io_display_port.md
# io_display_port

Memory-mapped output peripheral on the CPU data bus, downstream of the CPU alongside the main memory. It decodes CPU writes with address[15]=1 (the half the memory never sees), holds a display value, control bits and an LED word, and drives the four active-low 7-segment digits and the green LEDs. It adds leading-zero blanking and a prescaled blink, and gives the top level a combinational read-back path for I/O addresses.

## Interface
- BLINK_DIV, 25000000: clocks per blink half-period; must be ≥2.
- clock  in  1  CPU clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  16  CPU bus address.
- data  in  32  CPU write data.
- wren  in  1  CPU write enable.
- io_sel  out  1  combinational address[15]; the top level muxes io_q into the CPU read data when high.
- io_q  out  32  combinational read-back of the register at address.
- LEDG  out  10  LED register contents.
- HEX0_D..HEX3_D  out  7 each  active-low segments {g,f,e,d,c,b,a}; HEX0 is the least significant digit.

## Operation
- Register map, decoded on the full 16-bit address:
  - 0x8000 DISP: data[15:0].
  - 0x8001 CTRL: data[2:0]. bit0 enable, bit1 leading-zero blank, bit2 blink.
  - 0x8002 LED: data[9:0].
- Any other 0x8xxx write is ignored. Writes with address[15]=0 are ignored.
- A write happens on a rising edge with wren=1 and a matching address. Unused data bits are discarded.
- io_q:
  - 0x8000: zero-extended DISP.
  - 0x8001: zero-extended CTRL.
  - 0x8002: zero-extended LED.
  - any other address: 0.
- Reset values: DISP=0, CTRL=3'b001, LED=0, blink counter=0, blink phase=0, HEX0..3_D=7'h7F (all off). LEDG follows the LED register (0).
- Digit nibbles: digit k = DISP[4k+3:4k].
- Segment codes, 0..F in order: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
- Leading-zero blank (CTRL bit1=1):
  - digit3 blanks if it is 0.
  - digit2 blanks if digits 3..2 are all 0.
  - digit1 blanks if digits 3..1 are all 0.
  - digit0 never blanks.
  - A blanked digit drives 7'h7F.
- Blink prescaler:
  - Counter runs 0..BLINK_DIV-1 and wraps to 0. Phase toggles on each wrap.
  - Counter and phase run regardless of the blink bit.
  - Any CTRL write clears the counter and the phase to 0. This takes priority over a wrap in the same cycle.
- Output priority, highest first:
  1. enable=0 → all digits 7'h7F.
  2. blink=1 and phase=1 → all digits 7'h7F.
  3. Otherwise the decoded value, with blanking applied if enabled.

## Timing
- Register write: value visible on io_q and LEDG immediately after edge N, the edge where wren is sampled.
- HEX outputs are registered from the register state: a DISP/CTRL write at edge N appears on HEX at edge N+1.
- Blink:
  - After a CTRL write at edge N, the counter is 0 after edge N.
  - Phase becomes 1 after edge N+BLINK_DIV; HEX blanks at edge N+BLINK_DIV+1.
  - Phase returns to 0 after edge N+2·BLINK_DIV.
- Reset:
  - Assertion clears all state immediately, independent of clock, including a write in progress.
  - First edge after release with no write: HEX0..3_D = 7'h40 ("0000").
- Back-to-back writes on consecutive edges each take effect; the last write to a register wins.

## Test plan
- Reset/defaults: assert reset_n=0 mid-run → HEX=7F, LEDG=0, io_q(0x8001)=1. Release, one edge → all HEX=40.
- Display decode: write 0x8000=0x0000A3C5 → one edge later HEX3..0 = 08,30,46,12. io_q(0x8000)=0xA3C5. Write 0x8000=0x89EF then 0x1234 on consecutive edges → final HEX3..0 = 79,24,30,19.
- Blanking: CTRL=3'b011, DISP=0x0070 → HEX3=7F, HEX2=7F, HEX1=78, HEX0=40. DISP=0x0000 → only HEX0 lit (40).
- Blink (BLINK_DIV=4): write CTRL=3'b101 at edge N → HEX lit through edge N+4, all 7F on edges N+5..N+8, lit again at N+9. A CTRL rewrite coinciding with a wrap keeps phase 0.
- Decode/readback: write 0x0002 (address[15]=0) → LED unchanged. Write 0x8003 → no register changes, io_q(0x8003)=0. Write 0x8002=0xFFFFFFFF → LEDG=0x3FF, io_sel=1.
- Enable off: CTRL=0 with DISP=0x1234 → all HEX=7F. LEDG is unaffected.
